// File: rtl/dither_pkg.sv
// Shared types and constants for the ordered dither stream.
// Holds the mode encoding, the 4x4 Bayer matrix and threshold scaling.
package dither_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC    = 2'd0,
        MODE_ORDERED  = 2'd1,
        MODE_TEMPORAL = 2'd2,
        MODE_ERRDIFF  = 2'd3
    } mode_e;

    // Row-major, indexed by {y, x}
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    function automatic logic [7:0] threshold_scale(
        input logic [3:0] t,
        input int         frac_w
    );
        logic [7:0] w;
        w = {4'b0, t};
        if (frac_w >= 4) return w << (frac_w - 4);
        else             return w >> (4 - frac_w);
    endfunction

endpackage

// File: rtl/dither_channel.sv
// Per-channel quantiser: truncate, ordered threshold bump with saturation.
// Error-diffusion carry exists only when DITHER_ERRDIFF_EN is defined.
module dither_channel
    import dither_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [IN_W-1:0]  pix,
    input  logic [3:0]       t,
    input  mode_e            mode,
    input  logic             sof,
    input  logic             eol,
    output logic [OUT_W-1:0] q
);
    localparam int FRAC_W = IN_W - OUT_W;

    logic [OUT_W-1:0]  hi;
    logic [FRAC_W-1:0] lo;
    logic [7:0]        ts;
    logic              bump;
    logic [OUT_W-1:0]  ord_q;

    assign hi    = pix[IN_W-1:FRAC_W];
    assign lo    = pix[FRAC_W-1:0];
    assign ts    = threshold_scale(t, FRAC_W);
    assign bump  = (hi != '1) && (8'(lo) > ts);
    assign ord_q = hi + OUT_W'(bump);

`ifdef DITHER_ERRDIFF_EN
    logic [FRAC_W-1:0] carry;
    logic [FRAC_W-1:0] cin;
    logic [IN_W:0]     v;
    logic              sat;
    logic [OUT_W-1:0]  ed_q;

    assign cin  = sof ? '0 : carry;
    assign v    = {1'b0, pix} + (IN_W+1)'(cin);
    assign sat  = v[IN_W];
    assign ed_q = sat ? '1 : v[IN_W-1:FRAC_W];

    // Carry is only meaningful within one error-diffusion line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= '0;
        end else if (load) begin
            if (mode != MODE_ERRDIFF || eol || sat) carry <= '0;
            else                                    carry <= v[FRAC_W-1:0];
        end
    end
`else
    logic unused_ed;
    assign unused_ed = ^{clk, rst_n, load, sof, eol};
`endif

    always_comb begin
        q = hi;
        case (mode)
            MODE_ORDERED,
            MODE_TEMPORAL: q = ord_q;
`ifdef DITHER_ERRDIFF_EN
            MODE_ERRDIFF:  q = ed_q;
`endif
            default:       q = hi;
        endcase
    end

endmodule

// File: rtl/ordered_dither_stream.sv
// Streaming 4x4 Bayer colour-depth reducer, 2-stage valid/ready pipeline.
// Define DITHER_ERRDIFF_EN to enable mode 3 (1-D error diffusion).
module ordered_dither_stream
    import dither_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 4,
    parameter int CHANNELS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                mode,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CHANNELS*IN_W-1:0]  s_data,
    input  logic                      s_sof,
    input  logic                      s_eol,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [CHANNELS*OUT_W-1:0] m_data,
    output logic                      m_sof,
    output logic                      m_eol
);
    localparam int FRAC_W = IN_W - OUT_W;

    if (FRAC_W < 1 || FRAC_W > 8) begin : g_bad_width
        $error("ordered_dither_stream: IN_W-OUT_W must be 1..8");
    end

    logic v1, v2, ld1, ld2, acc, adv;

    assign ld2     = !v2 || m_ready;
    assign ld1     = !v1 || ld2;
    assign s_ready = ld1;
    assign acc     = s_valid && s_ready;
    assign adv     = v1 && ld2;
    assign m_valid = v2;

    logic [1:0] x, y, fc, frame_fc;
    logic [1:0] x_use, y_use, fc_use, tx, ty;
    mode_e      frame_mode, mode_use;
    logic [3:0] t_next;

    // Temporal rotation: fc[0] shifts a column, fc[1] shifts half the matrix
    always_comb begin
        x_use    = s_sof ? 2'd0 : x;
        y_use    = s_sof ? 2'd0 : y;
        fc_use   = s_sof ? fc : frame_fc;
        mode_use = s_sof ? mode_e'(mode) : frame_mode;
        tx       = x_use;
        ty       = y_use;
        if (mode_use == MODE_TEMPORAL) begin
            tx = x_use + {1'b0, fc_use[0]};
            ty = y_use + {fc_use[1], 1'b0};
        end
        t_next = BAYER[{ty, tx}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            fc         <= '0;
            frame_fc   <= '0;
            frame_mode <= MODE_TRUNC;
        end else if (acc) begin
            x <= s_eol ? 2'd0 : x_use + 2'd1;
            y <= s_eol ? y_use + 2'd1 : y_use;
            if (s_sof) begin
                fc         <= fc + 2'd1;
                frame_fc   <= fc;
                frame_mode <= mode_use;
            end
        end
    end

    logic [CHANNELS*IN_W-1:0] d1;
    logic                     sof1, eol1;
    logic [3:0]               t1;
    mode_e                    mode1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            d1    <= '0;
            sof1  <= 1'b0;
            eol1  <= 1'b0;
            t1    <= '0;
            mode1 <= MODE_TRUNC;
        end else if (ld1) begin
            v1 <= s_valid;
            if (s_valid) begin
                d1    <= s_data;
                sof1  <= s_sof;
                eol1  <= s_eol;
                t1    <= t_next;
                mode1 <= mode_use;
            end
        end
    end

    logic [CHANNELS*OUT_W-1:0] q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        dither_channel #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (adv),
            .pix   (d1[c*IN_W +: IN_W]),
            .t     (t1),
            .mode  (mode1),
            .sof   (sof1),
            .eol   (eol1),
            .q     (q[c*OUT_W +: OUT_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            m_data <= '0;
            m_sof  <= 1'b0;
            m_eol  <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                m_data <= q;
                m_sof  <= sof1;
                m_eol  <= eol1;
            end
        end
    end

endmodule

// File: tb/tb_ordered_dither_stream.sv
// Directed bench for ordered_dither_stream (default 8->4 bits, 3 channels).
// Mode 3 vectors follow DITHER_ERRDIFF_EN.
module tb_ordered_dither_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_eol = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [11:0] m_data;
    logic        m_sof;
    logic        m_eol;

    int n_cmp = 0;
    int n_bad = 0;

    int bay [4][4] = '{
        '{0, 8, 2, 10},
        '{12, 4, 14, 6},
        '{3, 11, 1, 9},
        '{15, 7, 13, 5}
    };

    ordered_dither_stream dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sof   (s_sof),
        .s_eol   (s_eol),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_q(input logic [7:0] d, input int t);
        logic [3:0] hi;
        hi = d[7:4];
        if (hi == 4'hF) return hi;
        return (int'(d[3:0]) > t) ? hi + 4'd1 : hi;
    endfunction

    // One isolated pixel through an idle pipeline, m_ready held high
    task automatic px(input string tag, input logic [7:0] d, input bit sof,
                      input bit eol, input logic [3:0] e);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = {3{d}};
        s_sof   = sof;
        s_eol   = eol;
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        @(negedge clk);
        check({tag, "_v"}, m_valid, 1);
        check(tag, m_data, {3{e}});
        check({tag, "_sof"}, m_sof, sof);
        check({tag, "_eol"}, m_eol, eol);
    endtask

    task automatic bp_run(input int n, input int duty, output int cycles);
        logic [13:0] exq[$];
        logic [13:0] hv, e;
        logic [23:0] d;
        logic [1:0]  mx, my;
        bit          held;
        int          sent;
        sent   = 0;
        held   = 1'b0;
        hv     = '0;
        mx     = '0;
        my     = '0;
        cycles = 0;
        while ((sent < n || exq.size() > 0) && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            if (held) begin
                check("hold_v", m_valid, 1);
                check("hold_d", {m_sof, m_eol, m_data}, hv);
            end
            m_ready = ($urandom_range(99) < duty);
            if (sent < n) begin
                d       = 24'($urandom);
                s_valid = 1'b1;
                s_data  = d;
                s_sof   = (sent == 0);
                s_eol   = (sent % 64 == 63);
            end else begin
                s_valid = 1'b0;
                s_sof   = 1'b0;
                s_eol   = 1'b0;
            end
            #1;
            if (s_valid && s_ready) begin
                if (s_sof) begin
                    mx = '0;
                    my = '0;
                end
                e = {s_sof, s_eol,
                     ref_q(d[23:16], bay[my][mx]),
                     ref_q(d[15:8], bay[my][mx]),
                     ref_q(d[7:0], bay[my][mx])};
                exq.push_back(e);
                if (s_eol) begin
                    mx = '0;
                    my = my + 2'd1;
                end else begin
                    mx = mx + 2'd1;
                end
                sent++;
            end
            if (m_valid && m_ready) begin
                if (exq.size() == 0) check("bp_extra", m_valid, 0);
                else check("bp_data", {m_sof, m_eol, m_data}, exq.pop_front());
            end
            held = m_valid && !m_ready;
            hv   = {m_sof, m_eol, m_data};
        end
        check("bp_done", exq.size() + (n - sent), 0);
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        m_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_msof", m_sof, 0);
        check("rst_meol", m_eol, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sready", s_ready, 1);

        // Ordered: (0,0) T=0, (1,0) T=8
        mode = 2'd1;
        px("ord_00", 8'h37, 1, 0, 4'h4);
        px("ord_10", 8'h37, 0, 0, 4'h3);
        px("sat_f9", 8'hF9, 1, 0, 4'hF);
        px("sat_ef", 8'hEF, 1, 0, 4'hF);
        px("x0", 8'h00, 1, 0, 4'h0);
        px("x1", 8'h00, 0, 0, 4'h0);
        px("x2", 8'h00, 0, 0, 4'h0);
        px("x3_t10", 8'h0F, 0, 1, 4'h1);
        px("y1_eq12", 8'h3C, 0, 0, 4'h3);
        px("sofeol", 8'h37, 1, 1, 4'h4);
        px("after_se", 8'h37, 0, 0, 4'h3);

        // Async reset mid-line
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = {3{8'h37}};
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_v", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_v", m_valid, 0);
        check("async_d", m_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        px("post_rst_trunc", 8'h37, 0, 0, 4'h3);

        // Temporal: fc 0..3 on successive sof pixels
        mode = 2'd2;
        px("tmp_fc0", 8'h37, 1, 0, 4'h4);
        px("tmp_fc1", 8'h37, 1, 0, 4'h3);
        px("tmp_fc2", 8'h37, 1, 0, 4'h4);
        px("tmp_fc3", 8'h37, 1, 0, 4'h3);

        // Mode change mid-frame is ignored until next sof
        mode = 2'd1;
        px("mc_sof", 8'h37, 1, 0, 4'h4);
        mode = 2'd0;
        px("mc_10", 8'h37, 0, 0, 4'h3);
        px("mc_20", 8'h37, 0, 0, 4'h4);
        px("mc_new", 8'h37, 1, 0, 4'h3);

        mode = 2'd3;
`ifdef DITHER_ERRDIFF_EN
        px("ed_0", 8'h08, 1, 0, 4'h0);
        px("ed_1", 8'h08, 0, 0, 4'h1);
        px("ed_2", 8'h08, 0, 1, 4'h0);
        px("ed_nl0", 8'h08, 0, 0, 4'h0);
        px("ed_nl1", 8'h08, 0, 0, 4'h1);
        px("ed_satff", 8'hFF, 0, 0, 4'hF);
`else
        px("m3_trunc", 8'h37, 1, 0, 4'h3);
`endif

        // Backpressure and throughput in ordered mode
        mode = 2'd1;
        bp_run(128, 30, cyc);
        bp_run(16, 100, cyc);
        check("thruput", cyc, 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
